lc3_decode: RTL and testbench
=============================

LC3_DECODE -- requirements
Module: lc3_decode

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed (16-bit datapath, LC-3 ISA).
REQ-002 The block SHALL have the port `clock  in  1` as its single clock; all state updates on the posedge.
REQ-003 The block SHALL have the port `reset  in  1`: synchronous, active-high.
REQ-004 The block SHALL have the port `enable_decode  in  1`: capture/decode strobe from the pipeline controller.
REQ-005 The block SHALL have the port `npc_in  in  16`: next-PC from fetch.
REQ-006 The block SHALL have the port `instr_dout  in  16`: instruction word from instruction memory.
REQ-007 The block SHALL have the port `ir  out  16`: registered instruction.
REQ-008 The block SHALL have the port `npc_out  out  16`: registered next-PC.
REQ-009 The block SHALL have the port `e_control  out  6`: {alu_control[5:4], pcselect1[3:2], pcselect2[1], op2select[0]}.
REQ-010 The block SHALL have the port `w_control  out  2`: writeback source select.
REQ-011 The block SHALL have the port `mem_control  out  1`: indirect-access flag.
REQ-012 The block SHALL have the port `illegal  out  1`: registered flag, unsupported opcode decoded.
REQ-013 The block SHALL have the port `illegal_cnt  out  8`, present only under DECODE_ILLEGAL_CNT_EN.

Function
REQ-014 When enable_decode=1 at a posedge, the block SHALL load ir<=instr_dout and npc_out<=npc_in, and load all control outputs decoded from instr_dout; latency is exactly 1 cycle.
REQ-015 When enable_decode=0, all outputs SHALL hold their previous values (stall).
REQ-016 Opcode = instr_dout[15:12]; alu_control SHALL be ADD(0001)=00, AND(0101)=01, NOT(1001)=10, and 00 for all others.
REQ-017 pcselect1 SHALL be 01 for BR(0000), LD(0010), ST(0011), LDI(1010), STI(1011), LEA(1110); 10 for LDR(0110), STR(0111); 11 for JMP(1100); 00 otherwise.
REQ-018 pcselect2 SHALL be 1 for BR, LD, ST, LDI, STI, LEA; 0 otherwise.
REQ-019 op2select SHALL be 1 for NOT, and for ADD/AND when instr_dout[5]=0; 0 for ADD/AND when instr_dout[5]=1; 0 otherwise.
REQ-020 w_control SHALL be 00 for ADD/AND/NOT, 01 for LEA, 10 for LD/LDR/LDI, and 00 otherwise.
REQ-021 mem_control SHALL be 1 for LDI/STI and 0 otherwise.
REQ-022 For unsupported opcodes (0100, 1000, 1101, 1111) the block SHALL capture ir/npc_out normally, drive e_control=000000, w_control=00, mem_control=0, and set illegal=1.
REQ-023 illegal SHALL be 0 after any enabled capture of a supported opcode; it SHALL hold when enable_decode=0.
REQ-024 Decode SHALL be purely a function of the captured word; no inter-instruction state other than illegal_cnt.

Reset
REQ-025 reset=1 at a posedge SHALL clear ir, npc_out, e_control, w_control, mem_control, illegal, and illegal_cnt to 0.
REQ-026 reset SHALL take priority over enable_decode when both are asserted in the same cycle.
REQ-027 Outputs SHALL be 0 on the first posedge after reset deasserts unless enable_decode=1 on that edge.

Configuration
REQ-028 With DECODE_ILLEGAL_CNT_EN defined, illegal_cnt SHALL increment by 1 on each enabled capture of an unsupported opcode, saturating at 8'hFF, and clear only on reset.
REQ-029 Without DECODE_ILLEGAL_CNT_EN, the illegal_cnt port and counter logic SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-030 The bench SHALL cover this reset scenario: reset=1 with enable_decode=1 and instr_dout=16'h1042 -> the next cycle shows all outputs 0.
REQ-031 The bench SHALL cover this ADD-register scenario: enable_decode=1, instr_dout=16'h1283 (ADD R1,R2,R3), npc_in=16'h3001 -> the next cycle shows ir=16'h1283, npc_out=16'h3001, e_control=6'b000001, w_control=00, mem_control=0, illegal=0.
REQ-032 The bench SHALL cover this LDI scenario: enable_decode=1, instr_dout=16'hA405 -> the next cycle shows e_control=6'b000110, w_control=10, mem_control=1.
REQ-033 The bench SHALL cover this stall scenario: a JMP (16'hC080) is captured, then enable_decode=0 for 3 cycles while instr_dout=16'h5020 -> ir stays 16'hC080 and e_control stays 6'b001100 throughout.
REQ-034 The bench SHALL cover this illegal-opcode scenario: 16'hD000 is captured 257 times with the macro defined -> illegal=1, controls are 0, and illegal_cnt saturates at 8'hFF; a following 16'h5020 capture -> illegal=0, e_control=6'b010000.
REQ-035 The bench SHALL cover this ADD-immediate scenario: instr_dout=16'h1265 (ADD imm) -> e_control=6'b000000 (op2select=0).

Source files
------------

// File: rtl/lc3_decode.sv
// rtl/lc3_decode.sv - LC-3 decode stage: registers IR/NPC and decodes execute/writeback/memory controls.
// Optional illegal-opcode counter port is built only when DECODE_ILLEGAL_CNT_EN is defined.
module lc3_decode (
  input  logic        clock,
  input  logic        reset,
  input  logic        enable_decode,
  input  logic [15:0] npc_in,
  input  logic [15:0] instr_dout,
  output logic [15:0] ir,
  output logic [15:0] npc_out,
  output logic [5:0]  e_control,
  output logic [1:0]  w_control,
  output logic        mem_control,
  output logic        illegal
`ifdef DECODE_ILLEGAL_CNT_EN
  ,
  output logic [7:0]  illegal_cnt
`endif
);

  localparam logic [3:0] OP_BR  = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_LD  = 4'b0010;
  localparam logic [3:0] OP_ST  = 4'b0011;
  localparam logic [3:0] OP_AND = 4'b0101;
  localparam logic [3:0] OP_LDR = 4'b0110;
  localparam logic [3:0] OP_STR = 4'b0111;
  localparam logic [3:0] OP_NOT = 4'b1001;
  localparam logic [3:0] OP_LDI = 4'b1010;
  localparam logic [3:0] OP_STI = 4'b1011;
  localparam logic [3:0] OP_JMP = 4'b1100;
  localparam logic [3:0] OP_LEA = 4'b1110;

  logic [3:0] opcode;
  logic [1:0] alu_control;
  logic [1:0] pcselect1;
  logic       pcselect2;
  logic       op2select;
  logic [1:0] dec_w_control;
  logic       dec_mem_control;
  logic       dec_illegal;

  assign opcode = instr_dout[15:12];

  // Unlisted opcodes fall to the default branch: all controls zero, illegal set.
  always_comb begin
    alu_control     = 2'b00;
    pcselect1       = 2'b00;
    pcselect2       = 1'b0;
    op2select       = 1'b0;
    dec_w_control   = 2'b00;
    dec_mem_control = 1'b0;
    dec_illegal     = 1'b0;
    case (opcode)
      OP_ADD: op2select = ~instr_dout[5];
      OP_AND: begin
        alu_control = 2'b01;
        op2select   = ~instr_dout[5];
      end
      OP_NOT: begin
        alu_control = 2'b10;
        op2select   = 1'b1;
      end
      OP_BR, OP_ST: begin
        pcselect1 = 2'b01;
        pcselect2 = 1'b1;
      end
      OP_LD: begin
        pcselect1     = 2'b01;
        pcselect2     = 1'b1;
        dec_w_control = 2'b10;
      end
      OP_LDI: begin
        pcselect1       = 2'b01;
        pcselect2       = 1'b1;
        dec_w_control   = 2'b10;
        dec_mem_control = 1'b1;
      end
      OP_STI: begin
        pcselect1       = 2'b01;
        pcselect2       = 1'b1;
        dec_mem_control = 1'b1;
      end
      OP_LEA: begin
        pcselect1     = 2'b01;
        pcselect2     = 1'b1;
        dec_w_control = 2'b01;
      end
      OP_LDR: begin
        pcselect1     = 2'b10;
        dec_w_control = 2'b10;
      end
      OP_STR: pcselect1 = 2'b10;
      OP_JMP: pcselect1 = 2'b11;
      default: dec_illegal = 1'b1;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      ir          <= 16'h0000;
      npc_out     <= 16'h0000;
      e_control   <= 6'b000000;
      w_control   <= 2'b00;
      mem_control <= 1'b0;
      illegal     <= 1'b0;
    end else if (enable_decode) begin
      ir          <= instr_dout;
      npc_out     <= npc_in;
      e_control   <= {alu_control, pcselect1, pcselect2, op2select};
      w_control   <= dec_w_control;
      mem_control <= dec_mem_control;
      illegal     <= dec_illegal;
    end
  end

`ifdef DECODE_ILLEGAL_CNT_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      illegal_cnt <= 8'h00;
    end else if (enable_decode && dec_illegal && (illegal_cnt != 8'hFF)) begin
      illegal_cnt <= illegal_cnt + 8'h01;
    end
  end
`endif

endmodule

// File: tb/tb_lc3_decode.sv
// tb/tb_lc3_decode.sv - randomized model-checked bench for lc3_decode, plus pinned literal scenarios.
// Honours DECODE_ILLEGAL_CNT_EN for the optional illegal_cnt port.
module tb_lc3_decode;
  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        enable_decode = 1'b0;
  logic [15:0] npc_in = 16'h0000;
  logic [15:0] instr_dout = 16'h0000;
  logic [15:0] ir, npc_out;
  logic [5:0]  e_control;
  logic [1:0]  w_control;
  logic        mem_control, illegal;
`ifdef DECODE_ILLEGAL_CNT_EN
  logic [7:0]  illegal_cnt;
`endif

  int vectors = 0;
  int miscompares = 0;

  lc3_decode dut (
    .clock(clock), .reset(reset), .enable_decode(enable_decode),
    .npc_in(npc_in), .instr_dout(instr_dout),
    .ir(ir), .npc_out(npc_out), .e_control(e_control), .w_control(w_control),
    .mem_control(mem_control), .illegal(illegal)
`ifdef DECODE_ILLEGAL_CNT_EN
    , .illegal_cnt(illegal_cnt)
`endif
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference decode written from the opcode tables: returns {e_control, w_control, mem, illegal}.
  function automatic logic [9:0] ref_decode(input logic [15:0] word);
    int op;
    int alu, ps1, ps2, op2, wc, mem, ill;
    logic [5:0] e;
    op = int'(word[15:12]);
    alu = 0; ps1 = 0; ps2 = 0; op2 = 0; wc = 0; mem = 0; ill = 0;
    if (op == 1) alu = 0;
    if (op == 5) alu = 1;
    if (op == 9) alu = 2;
    if (op inside {0, 2, 3, 10, 11, 14}) begin ps1 = 1; ps2 = 1; end
    if (op inside {6, 7}) ps1 = 2;
    if (op == 12) ps1 = 3;
    if (op == 9) op2 = 1;
    if (op inside {1, 5}) op2 = word[5] ? 0 : 1;
    if (op == 14) wc = 1;
    if (op inside {2, 6, 10}) wc = 2;
    if (op inside {10, 11}) mem = 1;
    if (op inside {4, 8, 13, 15}) ill = 1;
    e = 6'(alu * 16 + ps1 * 4 + ps2 * 2 + op2);
    return {e, 2'(wc), 1'(mem), 1'(ill)};
  endfunction

  logic [15:0] m_ir = 0, m_npc = 0;
  logic [5:0]  m_e = 0;
  logic [1:0]  m_w = 0;
  logic        m_mem = 0, m_ill = 0;
  int          m_cnt = 0;
  bit          model_valid = 0;

  always @(posedge clock) begin
    logic [9:0] d;
    d = ref_decode(instr_dout);
    if (reset) begin
      m_ir = 0; m_npc = 0; m_e = 0; m_w = 0; m_mem = 0; m_ill = 0; m_cnt = 0;
    end else if (enable_decode) begin
      m_ir = instr_dout; m_npc = npc_in;
      {m_e, m_w, m_mem, m_ill} = d;
      if (d[0] && m_cnt < 255) m_cnt = m_cnt + 1;
    end
    model_valid = 1;
  end

  always @(negedge clock) begin
    if (model_valid) begin
      check("model_ir", ir, m_ir);
      check("model_npc", npc_out, m_npc);
      check("model_e_control", 16'(e_control), 16'(m_e));
      check("model_w_control", 16'(w_control), 16'(m_w));
      check("model_mem_control", 16'(mem_control), 16'(m_mem));
      check("model_illegal", 16'(illegal), 16'(m_ill));
`ifdef DECODE_ILLEGAL_CNT_EN
      check("model_illegal_cnt", 16'(illegal_cnt), 16'(m_cnt));
`endif
    end
  end

  // Called at a negedge: drives inputs, returns at the next negedge (after one capture edge).
  task automatic apply(input logic r, input logic en, input logic [15:0] instr, input logic [15:0] npc);
    reset = r; enable_decode = en; instr_dout = instr; npc_in = npc;
    @(negedge clock);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ir"}, ir, 16'h0000);
    check({tag, "_npc"}, npc_out, 16'h0000);
    check({tag, "_e"}, 16'(e_control), 16'h0000);
    check({tag, "_w"}, 16'(w_control), 16'h0000);
    check({tag, "_mem"}, 16'(mem_control), 16'h0000);
    check({tag, "_ill"}, 16'(illegal), 16'h0000);
`ifdef DECODE_ILLEGAL_CNT_EN
    check({tag, "_cnt"}, 16'(illegal_cnt), 16'h0000);
`endif
  endtask

  initial begin
    @(negedge clock);
    check_all_zero("reset_state");

    apply(1, 1, 16'h1042, 16'h1234);
    check_all_zero("reset_priority");
    apply(0, 0, 16'h1042, 16'h1234);
    check_all_zero("post_reset_idle");

    apply(0, 1, 16'h1283, 16'h3001);
    check("add_reg_ir", ir, 16'h1283);
    check("add_reg_npc", npc_out, 16'h3001);
    check("add_reg_e", 16'(e_control), 16'(6'b000001));
    check("add_reg_w", 16'(w_control), 16'h0000);
    check("add_reg_mem", 16'(mem_control), 16'h0000);
    check("add_reg_ill", 16'(illegal), 16'h0000);

    apply(0, 1, 16'hA405, 16'h3002);
    check("ldi_e", 16'(e_control), 16'(6'b000110));
    check("ldi_w", 16'(w_control), 16'h0002);
    check("ldi_mem", 16'(mem_control), 16'h0001);

    apply(0, 1, 16'h1265, 16'h3003);
    check("add_imm_e", 16'(e_control), 16'(6'b000000));

    apply(0, 1, 16'hC080, 16'h3004);
    for (int i = 0; i < 3; i++) begin
      apply(0, 0, 16'h5020, 16'($urandom));
      check("stall_ir", ir, 16'hC080);
      check("stall_e", 16'(e_control), 16'(6'b001100));
      check("stall_npc", npc_out, 16'h3004);
    end

    apply(1, 0, 16'h0000, 16'h0000);
    for (int i = 0; i < 257; i++) apply(0, 1, 16'hD000, 16'(i));
    check("illegal_flag", 16'(illegal), 16'h0001);
    check("illegal_e", 16'(e_control), 16'h0000);
    check("illegal_w", 16'(w_control), 16'h0000);
    check("illegal_mem", 16'(mem_control), 16'h0000);
    check("illegal_ir", ir, 16'hD000);
`ifdef DECODE_ILLEGAL_CNT_EN
    check("illegal_cnt_sat", 16'(illegal_cnt), 16'h00FF);
`endif
    apply(0, 1, 16'h5020, 16'h4000);
    check("after_illegal_ill", 16'(illegal), 16'h0000);
    check("after_illegal_e", 16'(e_control), 16'(6'b010000));
`ifdef DECODE_ILLEGAL_CNT_EN
    check("cnt_holds", 16'(illegal_cnt), 16'h00FF);
`endif

    for (int i = 0; i < 3000; i++) begin
      apply(($urandom_range(0, 59) == 0), ($urandom_range(0, 3) != 0),
            16'($urandom), 16'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
